// File: rtl/dmem_access_ctrl_pkg.sv
// dmem_access_ctrl_pkg: state encoding and load funct3 codes shared by the data-memory path
package dmem_access_ctrl_pkg;
   typedef logic [1:0] state_t;
   localparam state_t S_IDLE = 2'd0;
   localparam state_t S_REQ  = 2'd1;
   localparam state_t S_WAIT = 2'd2;
   localparam state_t S_DONE = 2'd3;
   localparam logic [2:0] FNC_LB  = 3'b000;
   localparam logic [2:0] FNC_LH  = 3'b001;
   localparam logic [2:0] FNC_LW  = 3'b010;
   localparam logic [2:0] FNC_LBU = 3'b100;
   localparam logic [2:0] FNC_LHU = 3'b101;
endpackage

// File: rtl/dmem_access_ctrl_load_aligner.sv
// load_aligner: selects the addressed byte/half of a raw load word and sign/zero-extends it
module load_aligner
   import dmem_access_ctrl_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  off,
   input  logic [31:0] raw,
   output logic [31:0] data
);
   logic [7:0]  b;
   logic [15:0] h;
   assign b = raw[{off, 3'b000} +: 8];
   assign h = off[1] ? raw[31:16] : raw[15:0];
   // LW and any unlisted funct3 pass the word through untouched
   always_comb
      data = funct3 == FNC_LB  ? {{24{b[7]}}, b} :
             funct3 == FNC_LBU ? {24'd0, b} :
             funct3 == FNC_LH  ? {{16{h[15]}}, h} :
             funct3 == FNC_LHU ? {16'd0, h} : raw;
endmodule

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: sequences X-stage loads/stores onto a valid/ready dcache port,
// stalling the pipeline for the transaction and returning extended load data to writeback
module dmem_access_ctrl
   import dmem_access_ctrl_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              x_valid,
   input  logic              x_flush,
   input  logic              x_load,
   input  logic [3:0]        x_wmask,
   input  logic [ADDR_W-1:0] x_addr,
   input  logic [DATA_W-1:0] x_store_data,
   input  logic [2:0]        x_funct3,
   input  logic [4:0]        x_rd,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_req_addr,
   output logic [DATA_W-1:0] mem_req_din,
   output logic [3:0]        mem_req_wmask,
   output logic              mem_req_re,
   input  logic              mem_resp_valid,
   input  logic [DATA_W-1:0] mem_resp_data,
   output logic              stall,
   output logic              load_valid,
   output logic [4:0]        load_rd,
   output logic [DATA_W-1:0] load_data
);
   state_t            state;
   logic [ADDR_W-1:0] addr_q;
   logic [3:0]        wmask_q;
   logic [DATA_W-1:0] din_q;
   logic [2:0]        funct3_q;
   logic [4:0]        rd_q;
   logic              is_load_q;
   logic              start;
   logic [DATA_W-1:0] aligned;

   assign start = state == S_IDLE && x_valid && !x_flush && (x_load || x_wmask != 4'd0);
   // combinational so the issuing instruction is held in X on the start cycle
   assign stall         = start || state == S_REQ || state == S_WAIT;
   assign mem_req_valid = state == S_REQ;
   assign mem_req_addr  = {addr_q[ADDR_W-1:2], 2'b00};
   assign mem_req_din   = din_q;
   assign mem_req_wmask = wmask_q;
   assign mem_req_re    = mem_req_valid && is_load_q;
   assign load_valid    = state == S_DONE;

   load_aligner u_align (
      .funct3 (funct3_q),
      .off    (addr_q[1:0]),
      .raw    (mem_resp_data),
      .data   (aligned)
   );

   always_ff @(posedge clk)
      if (reset) begin
         state     <= S_IDLE;
         addr_q    <= '0;
         wmask_q   <= '0;
         din_q     <= '0;
         funct3_q  <= '0;
         rd_q      <= '0;
         is_load_q <= 1'b0;
         load_rd   <= '0;
         load_data <= '0;
      end else begin
         case (state)
            S_IDLE: if (start) begin
               state     <= S_REQ;
               addr_q    <= x_addr;
               wmask_q   <= x_load ? 4'd0 : x_wmask;
               din_q     <= x_store_data;
               funct3_q  <= x_funct3;
               rd_q      <= x_rd;
               is_load_q <= x_load;
            end
            S_REQ:  if (mem_req_ready) state <= is_load_q ? S_WAIT : S_IDLE;
            S_WAIT: if (mem_resp_valid) begin
               state     <= S_DONE;
               load_data <= aligned;
               load_rd   <= rd_q;
            end
            default: state <= S_IDLE;
         endcase
      end

   always_ff @(posedge clk)
      if (!reset && start)
         assert (!(x_load && x_wmask != 4'd0));
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: scoreboard bench with directed and randomized loads/stores
module tb_dmem_access_ctrl;
   logic        clk = 0;
   logic        reset;
   logic        x_valid, x_flush, x_load;
   logic [3:0]  x_wmask;
   logic [31:0] x_addr, x_store_data;
   logic [2:0]  x_funct3;
   logic [4:0]  x_rd;
   logic        mem_req_valid, mem_req_ready, mem_req_re;
   logic [31:0] mem_req_addr, mem_req_din;
   logic [3:0]  mem_req_wmask;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;
   logic        stall, load_valid;
   logic [4:0]  load_rd;
   logic [31:0] load_data;

   typedef struct packed {logic [31:0] addr; logic [31:0] din; logic [3:0] wmask; logic re;} req_t;
   typedef struct packed {logic [4:0] rd; logic [31:0] data;} ld_t;
   req_t rq[$];
   ld_t  lq[$];
   int   n_cmp = 0, n_fail = 0;
   int   stall_cnt, rv_cnt, lv_cnt;
   logic prev_resp = 0;

   dmem_access_ctrl dut (
      .clk(clk), .reset(reset), .x_valid(x_valid), .x_flush(x_flush), .x_load(x_load),
      .x_wmask(x_wmask), .x_addr(x_addr), .x_store_data(x_store_data), .x_funct3(x_funct3),
      .x_rd(x_rd), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_addr(mem_req_addr), .mem_req_din(mem_req_din), .mem_req_wmask(mem_req_wmask),
      .mem_req_re(mem_req_re), .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
      .stall(stall), .load_valid(load_valid), .load_rd(load_rd), .load_data(load_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // reference extension computed from byte/half positions with plain arithmetic
   function automatic logic [31:0] ref_load(input int f3, input int off, input logic [31:0] w);
      longint b, h;
      b = (longint'(w) >> (8 * off)) & 255;
      h = (longint'(w) >> (16 * (off / 2))) & 65535;
      case (f3)
         0: return (b >= 128) ? 32'(b - 256) : 32'(b);
         4: return 32'(b);
         1: return (h >= 32768) ? 32'(h - 65536) : 32'(h);
         5: return 32'(h);
         default: return w;
      endcase
   endfunction

   always @(negedge clk)
      if (!reset) begin
         if (stall) stall_cnt++;
         if (mem_req_valid) rv_cnt++;
         if (load_valid) lv_cnt++;
         if (mem_req_valid) begin
            if (rq.size() == 0) chk("unexpected_req", 1, 0);
            else begin
               chk("req_addr", mem_req_addr, rq[0].addr);
               chk("req_din", mem_req_din, rq[0].din);
               chk("req_wmask", {28'd0, mem_req_wmask}, {28'd0, rq[0].wmask});
               chk("req_re", {31'd0, mem_req_re}, {31'd0, rq[0].re});
               if (mem_req_ready) void'(rq.pop_front());
            end
         end
         if (load_valid) begin
            if (lq.size() == 0) chk("unexpected_load_valid", 1, 0);
            else begin
               chk("load_data", load_data, lq[0].data);
               chk("load_rd", {27'd0, load_rd}, {27'd0, lq[0].rd});
               chk("load_after_resp", {31'd0, prev_resp}, 1);
               void'(lq.pop_front());
            end
         end
         prev_resp = mem_resp_valid;
      end

   task automatic access(input bit ld, input logic [3:0] wm, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] rw,
                         input int rdly, input int pdly, input bit flush_mid);
      stall_cnt = 0; rv_cnt = 0; lv_cnt = 0;
      x_valid = 1; x_load = ld; x_wmask = wm; x_addr = a; x_store_data = d; x_funct3 = f3; x_rd = rd;
      rq.push_back('{addr: a & ~32'h3, din: d, wmask: ld ? 4'd0 : wm, re: ld});
      if (ld) lq.push_back('{rd: rd, data: ref_load(f3, a[1:0], rw)});
      @(posedge clk); #1;
      x_valid = 0; x_load = 0; x_wmask = 0;
      for (int i = 0; i < rdly; i++) begin
         x_flush = flush_mid && i == 1;
         @(posedge clk); #1;
      end
      x_flush = 0; mem_req_ready = 1;
      @(posedge clk); #1;
      mem_req_ready = 0;
      if (ld) begin
         repeat (pdly) begin @(posedge clk); #1; end
         mem_resp_valid = 1; mem_resp_data = rw;
         @(posedge clk); #1;
         mem_resp_valid = 0; mem_resp_data = $urandom;
         @(posedge clk); #1;
      end
      chk("stall_cycles", stall_cnt, ld ? 3 + rdly + pdly : 2 + rdly);
      chk("req_valid_cycles", rv_cnt, rdly + 1);
      chk("load_valid_pulses", lv_cnt, {31'd0, ld});
   endtask

   initial begin
      logic [2:0] f3s [7] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6};
      reset = 1; x_valid = 0; x_flush = 0; x_load = 0; x_wmask = 0; x_addr = 0; x_store_data = 0;
      x_funct3 = 0; x_rd = 0; mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = 0;
      stall_cnt = 0; rv_cnt = 0; lv_cnt = 0;
      repeat (3) @(posedge clk);
      #1 reset = 0;
      @(negedge clk);
      chk("rst_stall", {31'd0, stall}, 0);
      chk("rst_req_valid", {31'd0, mem_req_valid}, 0);
      chk("rst_load_valid", {31'd0, load_valid}, 0);
      chk("rst_load_data", load_data, 0);
      chk("rst_req_addr", mem_req_addr, 0);
      @(posedge clk); #1;
      access(0, 4'hF, 32'h100, 32'hDEADBEEF, 3'd2, 5'd0, 0, 0, 0, 0);
      access(1, 4'h0, 32'h203, 32'h0, 3'd0, 5'd5, 32'h80FF1234, 0, 0, 0);
      access(1, 4'h0, 32'h202, 32'h0, 3'd5, 5'd9, 32'hBEEF0000, 0, 0, 0);
      access(0, 4'h3, 32'h154, 32'hCAFEF00D, 3'd1, 5'd0, 0, 5, 0, 1);
      // flushed load in IDLE plus a stray response: nothing may happen
      stall_cnt = 0; rv_cnt = 0; lv_cnt = 0;
      x_valid = 1; x_load = 1; x_flush = 1; x_addr = 32'h300; x_funct3 = 3'd2;
      repeat (3) begin @(posedge clk); #1; end
      mem_resp_valid = 1; mem_resp_data = 32'h12345678;
      @(posedge clk); #1;
      mem_resp_valid = 0; x_valid = 0; x_load = 0; x_flush = 0;
      @(posedge clk); #1;
      chk("flush_stall", stall_cnt, 0);
      chk("flush_req", rv_cnt, 0);
      chk("stray_resp_load_valid", lv_cnt, 0);
      // reset while waiting for a load response
      x_valid = 1; x_load = 1; x_addr = 32'h40; x_funct3 = 3'd2; x_rd = 5'd7;
      rq.push_back('{addr: 32'h40, din: x_store_data, wmask: 4'd0, re: 1'b1});
      @(posedge clk); #1;
      x_valid = 0; x_load = 0; mem_req_ready = 1;
      @(posedge clk); #1;
      mem_req_ready = 0; reset = 1;
      @(posedge clk); #1;
      reset = 0;
      @(negedge clk);
      chk("wait_rst_stall", {31'd0, stall}, 0);
      chk("wait_rst_req_valid", {31'd0, mem_req_valid}, 0);
      chk("wait_rst_load_data", load_data, 0);
      @(posedge clk); #1;
      stall_cnt = 0; lv_cnt = 0;
      mem_resp_valid = 1; mem_resp_data = 32'hA5A5A5A5;
      @(posedge clk); #1;
      mem_resp_valid = 0;
      repeat (2) begin @(posedge clk); #1; end
      chk("post_rst_resp_load_valid", lv_cnt, 0);
      chk("post_rst_stall", stall_cnt, 0);
      for (int n = 0; n < 40; n++) begin
         bit ld;
         ld = 1'($urandom_range(0, 1));
         access(ld, ld ? 4'd0 : 4'($urandom_range(1, 15)), $urandom, $urandom,
                ld ? f3s[$urandom_range(0, 6)] : 3'd2, 5'($urandom), $urandom,
                $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end
      chk("req_queue_drained", rq.size(), 0);
      chk("load_queue_drained", lq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Sequences every data-memory access issued by the execute stage.
- Latches address, write mask, store data, funct3 and rd from X, drives a valid/ready request to the data cache, and waits for the load response.
- Stalls the pipeline for the whole transaction and returns sign/zero-extended load data to writeback.
- Sits between X-stage control (DMem_re, MemRW, store_data) and the dcache port. It replaces the direct single-cycle memory hookup.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, data width. Only 32 is supported; the mask is DATA_W/8 = 4 bits.

Ports:
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- x_valid  input  1  X-stage instruction is valid (not a bubble)
- x_flush  input  1  X-stage instruction is being squashed (branch taken / branch_prev)
- x_load  input  1  X instruction is a load (DMem_re)
- x_wmask  input  4  byte write mask from X (MemRW); nonzero means store
- x_addr  input  ADDR_W  ALU-computed effective address
- x_store_data  input  DATA_W  lane-aligned store data
- x_funct3  input  3  load width/sign encoding
- x_rd  input  5  load destination register
- mem_req_valid  output  1  request valid to dcache
- mem_req_ready  input  1  dcache accepts request
- mem_req_addr  output  ADDR_W  word-aligned address ({addr[31:2],2'b00})
- mem_req_din  output  DATA_W  store data
- mem_req_wmask  output  4  byte enables (0 for loads)
- mem_req_re  output  1  read request
- mem_resp_valid  input  1  load data valid (1-cycle pulse)
- mem_resp_data  input  DATA_W  raw load word
- stall  output  1  freeze fetch/decode/execute
- load_valid  output  1  writeback strobe (1-cycle pulse)
- load_rd  output  5  writeback destination
- load_data  output  DATA_W  extended load result

Behaviour:
- States are IDLE, REQ, WAIT, DONE. Reset enters IDLE.
- Reset values: all outputs 0; captured registers 0.
- start = IDLE && x_valid && !x_flush && (x_load || x_wmask!=0).
- x_load and a nonzero x_wmask at the same time is illegal (assertion). Treat it as a load and force the wmask to 0.
- stall = start || state==REQ || state==WAIT. It is combinational so the issuing instruction is held in X during the start cycle.
- IDLE -> REQ on start. addr, wmask, din, funct3, rd and is_load are registered on that edge.
- REQ:
  - mem_req_valid=1, and request fields are driven only from the registers.
  - Fields must stay stable until mem_req_ready.
  - On valid&&ready: a store goes to IDLE (posted, complete on acceptance); a load goes to WAIT.
- WAIT:
  - mem_req_valid=0.
  - On mem_resp_valid, the aligned result is registered into load_data, then go to DONE.
- DONE: load_valid=1 and stall=0 for exactly one cycle, then go to IDLE. load_data and load_rd hold until the next load completes.
- Minimum latency with zero-wait ready and a response on the following cycle:
  - Store: stall high for 2 cycles.
  - Load: stall high for 3 cycles, load_valid in cycle 4.
- A new access starts only from IDLE. Its earliest start is the cycle after a store's acceptance or after DONE.
- x_flush:
  - Suppresses start in IDLE.
  - Ignored in REQ/WAIT/DONE, because the in-flight access belongs to an older, committed instruction.
- mem_resp_valid outside WAIT is ignored. This includes stale responses after reset.
- mem_req_ready outside REQ is ignored.
- Reset mid-transaction (REQ/WAIT/DONE): return to IDLE next edge, drop mem_req_valid, no load_valid.
- Load alignment, where off = addr[1:0]:
  - LB/LBU select byte off, then sign-extend (LB) or zero-extend (LBU).
  - LH/LHU select the half at addr[1] (bytes 1:0 or 3:2); addr[0] is ignored.
  - LW passes the word through.
  - Other funct3 values pass through.

Decomposition:
- Shared package/header holds:
  - the state encoding (2-bit localparams S_IDLE/S_REQ/S_WAIT/S_DONE);
  - the existing FNC_LB/LH/LW/LBU/LHU constants from the opcode header (reuse them; do not redefine).
- One combinational sub-module, load_aligner (funct3, off, raw word -> extended data), is shared with the writeback mux tests.
- The FSM and capture registers stay in dmem_access_ctrl.

Test Plan:
- SW, addr 0x100, wmask 1111, din 0xDEADBEEF, ready held high:
  - req_valid for exactly 1 cycle with addr 0x100, wmask 1111;
  - stall high 2 cycles;
  - no load_valid.
- LB at addr 0x203, resp word 0x80FF1234:
  - load_data 0xFFFFFF80, load_rd = x_rd;
  - load_valid 1 cycle, in the cycle after the response.
- LHU at addr 0x202, resp 0xBEEF0000:
  - load_data 0x0000BEEF;
  - mem_req_addr 0x200, mem_req_re=1, mem_req_wmask=0.
- ready low for 5 cycles during REQ:
  - addr/din/wmask stable throughout;
  - stall high throughout;
  - x_flush pulsed mid-wait does not cancel the request.
- x_flush=1 with a load in IDLE: no request, stall stays 0. A stray mem_resp_valid in IDLE leaves load_valid 0.
- reset asserted in WAIT: next cycle state IDLE, stall 0, req_valid 0. A subsequent response pulse produces no load_valid.
